// File: rtl/scale_coord_if.sv
// Coordinate beat channel from scale_coord_gen (master) to the pixel fetch/interpolation stage (slave).
interface scale_coord_if #(
  parameter int FRAC_BITS = 12
);
  logic                 coord_valid;
  logic                 coord_ready;
  logic [10:0]          src_x;
  logic [10:0]          src_y;
  logic [FRAC_BITS-1:0] frac_x;
  logic [FRAC_BITS-1:0] frac_y;
  logic                 line_end;
  logic                 frame_end;

  modport master (
    output coord_valid, src_x, src_y, frac_x, frac_y, line_end, frame_end,
    input  coord_ready
  );

  modport slave (
    input  coord_valid, src_x, src_y, frac_x, frac_y, line_end, frame_end,
    output coord_ready
  );
endinterface

// File: rtl/scale_coord_gen.sv
// Walks the target frame in raster order and emits clamped source coordinates per pixel.
// Optional macro SCALE_COORD_FRAC_EN: drive frac_x/frac_y for bilinear interpolation (tied to 0 otherwise).
module scale_coord_gen #(
  parameter int          FRAC_BITS = 12,
  parameter logic [10:0] SRC_H_NUM = 11'd1280,
  parameter logic [10:0] SRC_V_NUM = 11'd720
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [14:0]   x_scale,
  input  logic [14:0]   y_scale,
  input  logic [10:0]   TARGET_H_NUM,
  input  logic [10:0]   TARGET_V_NUM,
  scale_coord_if.master cif,
  output logic          busy,
  output logic          frame_done
);
  localparam int ACC_W = 26;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [10:0]      h_idx, v_idx, h_nxt, v_nxt;
  logic [ACC_W-1:0] x_acc, y_acc, xa_nxt, ya_nxt;
  logic [14:0]      x_sc, y_sc, xs_nxt, ys_nxt;
  logic [10:0]      h_num, v_num, hn_nxt, vn_nxt;
  logic             valid_nxt, beat_upd;
  logic [ACC_W-1:0] xi, yi;
  logic             sat_x, sat_y, le_nxt, fe_nxt;
  logic [10:0]      sx_nxt, sy_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h_idx;
    v_nxt     = v_idx;
    xa_nxt    = x_acc;
    ya_nxt    = y_acc;
    xs_nxt    = x_sc;
    ys_nxt    = y_sc;
    hn_nxt    = h_num;
    vn_nxt    = v_num;
    valid_nxt = cif.coord_valid;
    beat_upd  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          xs_nxt = x_scale;
          ys_nxt = y_scale;
          hn_nxt = TARGET_H_NUM;
          vn_nxt = TARGET_V_NUM;
          h_nxt  = '0;
          v_nxt  = '0;
          xa_nxt = '0;
          ya_nxt = '0;
          if (TARGET_H_NUM == 11'd0 || TARGET_V_NUM == 11'd0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            valid_nxt = 1'b1;
            beat_upd  = 1'b1;
          end
        end
      end
      RUN: begin
        if (cif.coord_valid && cif.coord_ready) begin
          if (cif.frame_end) begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
          end else if (cif.line_end) begin
            h_nxt    = '0;
            xa_nxt   = '0;
            v_nxt    = v_idx + 11'd1;
            ya_nxt   = y_acc + {{(ACC_W-15){1'b0}}, y_sc};
            beat_upd = 1'b1;
          end else begin
            h_nxt    = h_idx + 11'd1;
            xa_nxt   = x_acc + {{(ACC_W-15){1'b0}}, x_sc};
            beat_upd = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat outputs are computed from the post-update counters so they can be registered.
  always_comb begin
    xi     = xa_nxt >> FRAC_BITS;
    yi     = ya_nxt >> FRAC_BITS;
    sat_x  = xi > ACC_W'(SRC_H_NUM - 11'd1);
    sat_y  = yi > ACC_W'(SRC_V_NUM - 11'd1);
    sx_nxt = sat_x ? (SRC_H_NUM - 11'd1) : xi[10:0];
    sy_nxt = sat_y ? (SRC_V_NUM - 11'd1) : yi[10:0];
    le_nxt = (h_nxt == hn_nxt - 11'd1);
    fe_nxt = le_nxt && (v_nxt == vn_nxt - 11'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_idx           <= '0;
      v_idx           <= '0;
      x_acc           <= '0;
      y_acc           <= '0;
      x_sc            <= '0;
      y_sc            <= '0;
      h_num           <= '0;
      v_num           <= '0;
      cif.coord_valid <= 1'b0;
      cif.src_x       <= '0;
      cif.src_y       <= '0;
      cif.line_end    <= 1'b0;
      cif.frame_end   <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      h_idx           <= h_nxt;
      v_idx           <= v_nxt;
      x_acc           <= xa_nxt;
      y_acc           <= ya_nxt;
      x_sc            <= xs_nxt;
      y_sc            <= ys_nxt;
      h_num           <= hn_nxt;
      v_num           <= vn_nxt;
      cif.coord_valid <= valid_nxt;
      busy            <= (state_nxt != IDLE);
      frame_done      <= (state_nxt == DONE);
      if (beat_upd) begin
        cif.src_x     <= sx_nxt;
        cif.src_y     <= sy_nxt;
        cif.line_end  <= le_nxt;
        cif.frame_end <= fe_nxt;
      end
    end
  end

`ifdef SCALE_COORD_FRAC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cif.frac_x <= '0;
      cif.frac_y <= '0;
    end else if (beat_upd) begin
      cif.frac_x <= sat_x ? '0 : xa_nxt[FRAC_BITS-1:0];
      cif.frac_y <= sat_y ? '0 : ya_nxt[FRAC_BITS-1:0];
    end
  end
`else
  assign cif.frac_x = '0;
  assign cif.frac_y = '0;
`endif

endmodule

// File: doc/scale_coord_gen.md
# scale_coord_gen

Target-to-source coordinate generator for the video scaler datapath. On each frame start it latches the target frame size (`TARGET_H_NUM` / `TARGET_V_NUM`) and the fixed-point scale factors (`x_scale` / `y_scale`) produced by the key-driven scale configuration logic. It then walks the target frame in raster order and emits, per target pixel, the source pixel coordinate to fetch, under a valid/ready handshake toward the pixel fetch/interpolation stage.

## Interface
- `FRAC_BITS`, 12, fraction bits of `x_scale`/`y_scale`; 1.0 = 4096.
- `SRC_H_NUM`, 11'd1280, source frame width; `src_x` clamp limit.
- `SRC_V_NUM`, 11'd720, source frame height; `src_y` clamp limit.
- `clk` in 1: ddr_core_100MHz; one clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse that starts a frame walk.
- `x_scale` in 15: horizontal src/target ratio, unsigned Q(15-FRAC_BITS).FRAC_BITS.
- `y_scale` in 15: vertical ratio, same format.
- `TARGET_H_NUM` in 11: target pixels per line.
- `TARGET_V_NUM` in 11: target lines per frame.
- `coord_valid` out 1: coordinate beat valid.
- `coord_ready` in 1: downstream accepts the beat.
- `src_x` out 11: integer source column, clamped.
- `src_y` out 11: integer source row, clamped.
- `frac_x` out FRAC_BITS: horizontal fractional phase.
- `frac_y` out FRAC_BITS: vertical fractional phase.
- `line_end` out 1: beat is the last pixel of a target line.
- `frame_end` out 1: beat is the last pixel of the frame.
- `busy` out 1: high while not IDLE.
- `frame_done` out 1: one-cycle pulse when the walk completes.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**: `frame_start` latches `x_scale`, `y_scale`, `TARGET_H_NUM`, `TARGET_V_NUM` into shadow registers. Mid-frame changes to these inputs are ignored. The FSM then goes to RUN.
  - Exception: if either latched target dimension is 0, go straight to DONE. No beats are emitted.
- **RUN**: maintains `h_idx`/`v_idx` (11 bit) and `x_acc`/`y_acc` (26 bit, = idx × scale).
  - `src_x` = `x_acc[FRAC_BITS+10:FRAC_BITS]`, saturated to `SRC_H_NUM-1`. `src_y` is formed the same way and saturated to `SRC_V_NUM-1`.
  - `frac_*` = `acc[FRAC_BITS-1:0]`. When `src_*` is saturated, `frac_*` is forced to 0.
  - On each accepted beat (`coord_valid & coord_ready`):
    - If `h_idx` is not the last column: `h_idx`+1, and `x_acc` += latched `x_scale`.
    - Otherwise: `h_idx`=0, `x_acc`=0, `v_idx`+1, and `y_acc` += latched `y_scale`.
  - `line_end` = (`h_idx == H-1`). `frame_end` = `line_end & (v_idx == V-1)`.
  - Acceptance of the `frame_end` beat moves the FSM to DONE.
- **DONE**: `frame_done` is high for one cycle, then the FSM returns to IDLE.
- `frame_start` in RUN or DONE is ignored and not queued.
- `rst` at any point, including mid-frame, returns the block to IDLE, clears all counters and accumulators, and drops `coord_valid` in the same edge. No `frame_done` is produced.

## Timing
- Reset values: `coord_valid`, `line_end`, `frame_end`, `busy`, `frame_done`, `src_x`, `src_y`, `frac_x`, `frac_y` are all 0.
- All outputs are registered.
- Start latency:
  - Cycle N: `frame_start` is sampled.
  - Cycle N+1: `coord_valid`=1 with beat (0,0), and `busy`=1.
- Throughput is one beat per cycle while `coord_ready`=1.
- While `coord_valid & !coord_ready`, all beat outputs hold stable. `coord_valid` never drops without acceptance, except on `rst`.
- Completion:
  - The `frame_end` beat is accepted at edge M.
  - `frame_done`=1 in the cycle after M. `busy` stays 1 during that cycle.
  - IDLE and `busy`=0 the cycle after that.
  - The earliest accepted `frame_start` is in that IDLE cycle.
- Zero-size frame: `frame_done` in cycle N+1.

## Configuration
- `SCALE_COORD_FRAC_EN` defined: `frac_x`/`frac_y` are driven as above, for bilinear interpolation.
- `SCALE_COORD_FRAC_EN` undefined:
  - The `frac_*` ports remain but are tied to 0.
  - Accumulator fraction bits still accumulate, so integer coordinates are identical.
  - The fraction output registers are removed.

## Test plan
- Unity scale: `x_scale`=`y_scale`=4096, target 4×2, `coord_ready`=1.
  - Beats are (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1). `line_end` on beats 3 and 7, `frame_end` on beat 7.
  - `frame_done` occurs one cycle after beat 7.
- 2× downscale and 0.5× upscale:
  - `x_scale`=8192, target 3×1: `src_x` is 0,2,4.
  - `x_scale`=2048, target 4×1: `src_x` is 0,0,1,1 and `frac_x` is 0,2048,0,2048. With `SCALE_COORD_FRAC_EN` undefined, `frac_x` is all 0.
- Clamp: `SRC_H_NUM`=640, `x_scale`=8192, target 640×1.
  - `src_x`=2·idx up to idx 319.
  - From idx 320 onward, `src_x`=639 and `frac_x`=0.
- Backpressure: random `coord_ready` over a 5×3 frame.
  - Exactly 15 beats are accepted, in order, with no duplicates.
  - Outputs are stable across every stall.
  - A `frame_start` pulsed mid-frame has no effect.
- Zero and reset cases:
  - `TARGET_H_NUM`=0: no `coord_valid`, and `frame_done` one cycle after `frame_start`.
  - `rst` asserted after 5 beats of a 4×4 frame: `coord_valid`=0 next cycle and no `frame_done`. A fresh `frame_start` then restarts at (0,0).
- Input change mid-frame: changing `x_scale` and `TARGET_H_NUM` during RUN leaves the current frame unchanged. The next frame uses the new values.
